if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 8 +
 rtl/if_id_buffer.sv | 49 ++++
 2 files changed

// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: shared fetch/decode pipeline types and constants
package if_id_buffer_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_id_buffer.sv
// if_id_buffer: circular fetch buffer between IF and ID with flush and full-stall
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = if_id_buffer_pkg::NOP_INSTR
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_instr,
  input  logic                     i_flush,
  output logic                     o_if_stall,
  input  logic                     i_id_ready,
  output logic                     o_valid,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_instr,
  output logic [$clog2(DEPTH):0]   o_count
);
  import if_id_buffer_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  fetch_entry_t head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign o_if_stall = count == CW'(DEPTH);
  assign o_valid    = count != '0;
  assign o_count    = count;
  assign push       = i_valid && !o_if_stall && !i_flush;
  assign pop        = o_valid && i_id_ready && !i_flush;
  assign head       = mem[rd_ptr];
  assign o_pc       = o_valid ? head.pc : '0;
  assign o_instr    = o_valid ? head.instr : NOP_INSTR;
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: i_pc, instr: i_instr};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
